// File: rtl/dice_roll_controller.sv
// Die-roll sequencer: edge-detects die buttons, arbitrates, runs a timed tumble
// and holds the settled 1..N result for the seven-segment display path.
module dice_roll_controller #(
    parameter int unsigned ROLL_CYCLES = 64,
    parameter bit          JITTER_EN   = 1'b1,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] btn_in,
    input  logic       switchTest,
    output logic [2:0] die_sel,
    output logic [4:0] roll_value,
    output logic       busy,
    output logic       result_valid,
    output logic       roll_done
);

    // state  | meaning
    // IDLE   | waiting for a die button, display blank
    // ROLL   | tumble animation running, roll_cnt counting down
    // SHOW   | result held, a new press re-rolls
    // TEST   | display test mode, any roll aborted
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROLL = 2'd1,
        S_SHOW = 2'd2,
        S_TEST = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  die_sel_q, die_sel_d;
    logic [4:0]  tumbler_q, tumbler_d;
    logic [7:0]  roll_cnt_q, roll_cnt_d;
    logic [5:0]  btn_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic        roll_done_q, roll_done_d;

    logic [5:0]  rise;
    logic [2:0]  win_code;
    logic [4:0]  sides;
    logic [7:0]  roll_len;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            die_sel_q   <= 3'b001;
            tumbler_q   <= 5'd1;
            roll_cnt_q  <= 8'd0;
            btn_q       <= 6'd0;
            lfsr_q      <= LFSR_SEED;
            roll_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            die_sel_q   <= die_sel_d;
            tumbler_q   <= tumbler_d;
            roll_cnt_q  <= roll_cnt_d;
            btn_q       <= btn_in;
            lfsr_q      <= lfsr_d;
            roll_done_q <= roll_done_d;
        end
    end

    always_comb begin
        rise     = btn_in & ~btn_q;
        // Scan from the top so the lowest set bit (D4) is the last to win.
        win_code = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (rise[i]) win_code = 3'(i);
        end

        case (die_sel_q)
            3'b000:  sides = 5'd4;
            3'b001:  sides = 5'd6;
            3'b010:  sides = 5'd8;
            3'b011:  sides = 5'd10;
            3'b100:  sides = 5'd12;
            default: sides = 5'd20;
        endcase

        roll_len = 8'(ROLL_CYCLES) + (JITTER_EN ? {4'd0, lfsr_q[3:0]} : 8'd0);
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        state_d    = state_q;
        die_sel_d  = die_sel_q;
        tumbler_d  = tumbler_q;
        roll_cnt_d = roll_cnt_q;

        if (switchTest) begin
            state_d   = S_TEST;
            die_sel_d = 3'b111;
        end else begin
            case (state_q)
                S_IDLE, S_SHOW: begin
                    if (|rise) begin
                        state_d    = S_ROLL;
                        die_sel_d  = win_code;
                        tumbler_d  = 5'd1;
                        roll_cnt_d = roll_len;
                    end
                end
                S_ROLL: begin
                    tumbler_d  = (tumbler_q == sides) ? 5'd1 : tumbler_q + 5'd1;
                    roll_cnt_d = roll_cnt_q - 8'd1;
                    if (roll_cnt_q == 8'd1) state_d = S_SHOW;
                end
                default: begin
                    state_d   = S_IDLE;
                    die_sel_d = 3'b001;
                end
            endcase
        end

        roll_done_d = (state_q == S_ROLL) && (state_d == S_SHOW);
    end

    assign die_sel      = die_sel_q;
    assign busy         = (state_q == S_ROLL);
    assign result_valid = (state_q == S_SHOW);
    assign roll_done    = roll_done_q;
    assign roll_value   = (state_q == S_ROLL || state_q == S_SHOW) ? tumbler_q : 5'd0;

endmodule

// File: tb/tb_dice_roll_controller.sv
// Directed bench for dice_roll_controller: fixed-length instance (16 clocks, no
// jitter) and a jittered instance (64 + lfsr[3:0]) checked against an LFSR model.
module tb_dice_roll_controller;

    logic       clk;
    logic       rst0, rst1;
    logic [5:0] btn0, btn1;
    logic       sw0, sw1;
    logic [2:0] die0, die1;
    logic [4:0] val0, val1;
    logic       busy0, busy1, rv0, rv1, rd0, rd1;
    logic [15:0] m_lfsr;

    int total = 0;
    int bad   = 0;

    dice_roll_controller #(.ROLL_CYCLES(16), .JITTER_EN(1'b0), .LFSR_SEED(16'hACE1)) u_dut0 (
        .clk(clk), .reset(rst0), .btn_in(btn0), .switchTest(sw0),
        .die_sel(die0), .roll_value(val0), .busy(busy0),
        .result_valid(rv0), .roll_done(rd0)
    );

    dice_roll_controller #(.ROLL_CYCLES(64), .JITTER_EN(1'b1), .LFSR_SEED(16'hACE1)) u_dut1 (
        .clk(clk), .reset(rst1), .btn_in(btn1), .switchTest(sw1),
        .die_sel(die1), .roll_value(val1), .busy(busy1),
        .result_valid(rv1), .roll_done(rd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR for the jittered instance.
    always @(posedge clk) begin
        if (rst1) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        tick(); tick();
        total++;
        if ({die0, val0, busy0, rv0, rd0} !== {3'b001, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset0: die=%0d val=%0d busy=%0b rv=%0b rd=%0b want die=1 val=0 busy=0 rv=0 rd=0",
                     die0, val0, busy0, rv0, rd0);
        end
        total++;
        if ({die1, val1, busy1, rv1, rd1} !== {3'b001, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset1: die=%0d val=%0d busy=%0b rv=%0b rd=%0b want die=1 val=0 busy=0 rv=0 rd=0",
                     die1, val1, busy1, rv1, rd1);
        end
        rst0 = 1'b0; rst1 = 1'b0;
        tick();
    endtask

    task automatic test_d6_roll();
        btn0 = 6'b000010;
        tick();
        btn0 = 6'b000000;
        for (int k = 0; k < 16; k++) begin
            total++;
            if (busy0 !== 1'b1 || rv0 !== 1'b0 || die0 !== 3'b001 || val0 !== 5'((k % 6) + 1)) begin
                bad++;
                $display("FAIL d6_tumble k=%0d: busy=%0b rv=%0b die=%0d val=%0d want busy=1 rv=0 die=1 val=%0d",
                         k, busy0, rv0, die0, val0, (k % 6) + 1);
            end
            tick();
        end
        total++;
        if ({busy0, rv0, rd0, val0} !== {1'b0, 1'b1, 1'b1, 5'd5}) begin
            bad++;
            $display("FAIL d6_result: busy=%0b rv=%0b rd=%0b val=%0d want busy=0 rv=1 rd=1 val=5",
                     busy0, rv0, rd0, val0);
        end
        tick();
        total++;
        if ({rv0, rd0, val0} !== {1'b1, 1'b0, 5'd5}) begin
            bad++;
            $display("FAIL d6_hold: rv=%0b rd=%0b val=%0d want rv=1 rd=0 val=5", rv0, rd0, val0);
        end
    endtask

    task automatic test_d20_ignore();
        btn0 = 6'b100000;
        tick();
        btn0 = 6'b000000;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) btn0 = 6'b000001;
            if (k == 5) btn0 = 6'b000000;
            total++;
            if (busy0 !== 1'b1 || die0 !== 3'b101 || val0 !== 5'(k + 1)) begin
                bad++;
                $display("FAIL d20_tumble k=%0d: busy=%0b die=%0d val=%0d want busy=1 die=5 val=%0d",
                         k, busy0, die0, val0, k + 1);
            end
            tick();
        end
        total++;
        if ({rv0, rd0, die0, val0} !== {1'b1, 1'b1, 3'b101, 5'd17}) begin
            bad++;
            $display("FAIL d20_result: rv=%0b rd=%0b die=%0d val=%0d want rv=1 rd=1 die=5 val=17",
                     rv0, rd0, die0, val0);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        btn0 = 6'b100100;
        tick();
        btn0 = 6'b000000;
        for (int k = 0; k < 16; k++) begin
            total++;
            if (busy0 !== 1'b1 || die0 !== 3'b010 || val0 !== 5'((k % 8) + 1)) begin
                bad++;
                $display("FAIL simul_tumble k=%0d: busy=%0b die=%0d val=%0d want busy=1 die=2 val=%0d",
                         k, busy0, die0, val0, (k % 8) + 1);
            end
            tick();
        end
        total++;
        if ({rv0, rd0, die0, val0} !== {1'b1, 1'b1, 3'b010, 5'd1}) begin
            bad++;
            $display("FAIL simul_result: rv=%0b rd=%0b die=%0d val=%0d want rv=1 rd=1 die=2 val=1",
                     rv0, rd0, die0, val0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        btn0 = 6'b001000;
        tick();
        btn0 = 6'b000000;
        for (int k = 0; k < 16; k++) begin
            total++;
            if (busy0 !== 1'b1 || rv0 !== 1'b0 || die0 !== 3'b011 || val0 !== 5'((k % 10) + 1)) begin
                bad++;
                $display("FAIL reroll_tumble k=%0d: busy=%0b rv=%0b die=%0d val=%0d want busy=1 rv=0 die=3 val=%0d",
                         k, busy0, rv0, die0, val0, (k % 10) + 1);
            end
            tick();
        end
        total++;
        if ({rv0, rd0, die0, val0} !== {1'b1, 1'b1, 3'b011, 5'd7}) begin
            bad++;
            $display("FAIL reroll_result: rv=%0b rd=%0b die=%0d val=%0d want rv=1 rd=1 die=3 val=7",
                     rv0, rd0, die0, val0);
        end
        tick();
    endtask

    task automatic test_test_mode();
        btn0 = 6'b000010;
        tick();
        btn0 = 6'b000000;
        repeat (4) tick();
        sw0 = 1'b1;
        tick();
        total++;
        if ({die0, busy0, val0, rv0, rd0} !== {3'b111, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL test_enter: die=%0d busy=%0b val=%0d rv=%0b rd=%0b want die=7 busy=0 val=0 rv=0 rd=0",
                     die0, busy0, val0, rv0, rd0);
        end
        for (int i = 0; i < 20; i++) begin
            if (i == 5) btn0 = 6'b000001;
            if (i == 7) btn0 = 6'b000000;
            tick();
            total++;
            if ({die0, busy0, val0, rv0, rd0} !== {3'b111, 1'b0, 5'd0, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL test_hold i=%0d: die=%0d busy=%0b val=%0d rv=%0b rd=%0b want die=7 busy=0 val=0 rv=0 rd=0",
                         i, die0, busy0, val0, rv0, rd0);
            end
        end
        sw0 = 1'b0;
        tick();
        total++;
        if ({die0, busy0, val0, rv0, rd0} !== {3'b001, 1'b0, 5'd0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL test_exit: die=%0d busy=%0b val=%0d rv=%0b rd=%0b want die=1 busy=0 val=0 rv=0 rd=0",
                     die0, busy0, val0, rv0, rd0);
        end
    endtask

    task automatic test_jitter();
        int len;
        int k;
        btn1 = 6'b010000;
        k    = int'(m_lfsr[3:0]);
        len  = 64 + k;
        tick();
        btn1 = 6'b000000;
        for (int c = 0; c < len; c++) begin
            total++;
            if (busy1 !== 1'b1 || die1 !== 3'b100 || val1 !== 5'((c % 12) + 1)) begin
                bad++;
                $display("FAIL jitter_tumble c=%0d L=%0d: busy=%0b die=%0d val=%0d want busy=1 die=4 val=%0d",
                         c, len, busy1, die1, val1, (c % 12) + 1);
            end
            tick();
        end
        total++;
        if ({busy1, rv1, rd1, val1} !== {1'b0, 1'b1, 1'b1, 5'((len % 12) + 1)}) begin
            bad++;
            $display("FAIL jitter_result L=%0d: busy=%0b rv=%0b rd=%0b val=%0d want busy=0 rv=1 rd=1 val=%0d",
                     len, busy1, rv1, rd1, val1, (len % 12) + 1);
        end
        tick();
    endtask

    task automatic test_reset_midroll();
        btn1 = 6'b100000;
        tick();
        btn1 = 6'b000000;
        repeat (10) tick();
        total++;
        if (busy1 !== 1'b1 || die1 !== 3'b101) begin
            bad++;
            $display("FAIL midroll_busy: busy=%0b die=%0d want busy=1 die=5", busy1, die1);
        end
        rst1 = 1'b1;
        tick();
        total++;
        if ({die1, val1, busy1, rv1, rd1} !== {3'b001, 5'd0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midroll_reset: die=%0d val=%0d busy=%0b rv=%0b rd=%0b want die=1 val=0 busy=0 rv=0 rd=0",
                     die1, val1, busy1, rv1, rd1);
        end
        rst1 = 1'b0;
        for (int i = 0; i < 90; i++) begin
            tick();
            total++;
            if ({busy1, rv1, rd1, val1} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin
                bad++;
                $display("FAIL midroll_nopend i=%0d: busy=%0b rv=%0b rd=%0b val=%0d want all 0",
                         i, busy1, rv1, rd1, val1);
            end
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        btn0 = 6'd0; btn1 = 6'd0;
        sw0  = 1'b0; sw1  = 1'b0;
        test_reset();
        test_d6_roll();
        test_d20_ignore();
        test_simultaneous();
        test_back_to_back();
        test_test_mode();
        test_jitter();
        test_reset_midroll();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
